// File: rtl/alu_result_buffer_if.sv
// Producer/consumer handshake bundle for the ALU result buffer.
// slave is the buffer's view; master is the view of the environment driving it.
interface alu_result_buffer_if #(
  parameter int N = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [N+2:0]   in_res;
  logic [2:0]     in_op;
  logic           out_valid;
  logic           out_ready;
  logic [N+2:0]   out_res;
  logic [2:0]     out_op;
  logic           out_zero;
  logic           out_neg;

  modport slave (
    input  in_valid, in_res, in_op, out_ready,
    output in_ready, out_valid, out_res, out_op, out_zero, out_neg
  );

  modport master (
    output in_valid, in_res, in_op, out_ready,
    input  in_ready, out_valid, out_res, out_op, out_zero, out_neg
  );
endinterface

// File: rtl/alu_result_buffer.sv
// Show-ahead FIFO capturing ALU results with opcode and zero/negative flags,
// plus a saturating counter of pushes rejected while full.
module alu_result_buffer #(
  parameter int N     = 3,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_result_buffer_if.slave   bus,
  output logic [AW:0]          count,
  output logic [7:0]           drop_cnt
);
  localparam int W = N + 3;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DEPTH-1:0][W-1:0] mem_res;
  logic [DEPTH-1:0][2:0]   mem_op;
  logic [DEPTH-1:0]        mem_zero;
  logic [DEPTH-1:0]        mem_neg;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Handshakes use the registered occupancy only: a pop never opens a slot the same cycle.
  assign push  = bus.in_valid & ~full;
  assign pop   = bus.out_ready & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      mem_res  <= '0;
      mem_op   <= '0;
      mem_zero <= '0;
      mem_neg  <= '0;
    end else begin
      if (push) begin
        mem_res[wr_ptr]  <= bus.in_res;
        mem_op[wr_ptr]   <= bus.in_op;
        mem_zero[wr_ptr] <= (bus.in_res == '0);
        mem_neg[wr_ptr]  <= bus.in_res[W-1];
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (bus.in_valid && full && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_res   = mem_res[rd_ptr];
  assign bus.out_op    = mem_op[rd_ptr];
  assign bus.out_zero  = mem_zero[rd_ptr];
  assign bus.out_neg   = mem_neg[rd_ptr];
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed and randomized checks of alu_result_buffer against a queue-based model.
module tb_alu_result_buffer;
  localparam int N     = 3;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = N + 3;

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   op;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW:0]   count;
  logic [7:0]    drop_cnt;

  alu_result_buffer_if #(.N(N)) bus ();

  alu_result_buffer #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  entry_t q[$];
  int     model_drops = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    check("count", 32'(count), 32'(q.size()));
    check("drop_cnt", 32'(drop_cnt), 32'(model_drops));
    if (q.size() > 0) begin
      check("out_res", 32'(bus.out_res), 32'(q[0].res));
      check("out_op", 32'(bus.out_op), 32'(q[0].op));
      check("out_zero", 32'(bus.out_zero), 32'(q[0].res == 0));
      check("out_neg", 32'(bus.out_neg), 32'($signed(q[0].res) < 0));
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, check half a cycle later.
  task automatic step(input logic iv, input logic [W-1:0] r, input logic [2:0] o,
                      input logic ordy, input logic rst);
    entry_t e;
    bit     can_push;
    bit     can_pop;
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_res    = r;
    bus.in_op     = o;
    bus.out_ready = ordy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      model_drops = 0;
    end else begin
      can_push = iv && (q.size() < DEPTH);
      can_pop  = ordy && (q.size() > 0);
      if (iv && !can_push && model_drops < 255) model_drops++;
      if (can_pop) void'(q.pop_front());
      if (can_push) begin
        e.res = r;
        e.op  = o;
        q.push_back(e);
      end
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_res    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset state, storage cleared
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("reset_out_res", 32'(bus.out_res), 32'd0);
    check("reset_out_op", 32'(bus.out_op), 32'd0);
    check("reset_out_flags", 32'({bus.out_zero, bus.out_neg}), 32'd0);

    // Single negative entry
    step(1'b1, 6'b111010, 3'b011, 1'b0, 1'b0);
    check("single_neg", 32'(bus.out_neg), 32'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Fill, overflow, drain
    for (int i = 0; i < 4; i++) step(1'b1, 6'(i), 3'(i), 1'b0, 1'b0);
    step(1'b1, 6'd9, 3'd1, 1'b0, 1'b0);
    check("overflow_drop", 32'(drop_cnt), 32'd1);
    check("first_zero", 32'(bus.out_zero), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Simultaneous push/pop at count=2, then mixed traffic across the pointer wrap
    step(1'b1, 6'd7, 3'd2, 1'b0, 1'b0);
    step(1'b1, 6'd8, 3'd3, 1'b0, 1'b0);
    step(1'b1, 6'd5, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 6'($urandom), 3'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Full, pop with push attempt: push dropped, next cycle accepted
    for (int i = 0; i < 4; i++) step(1'b1, 6'(i + 20), 3'(i), 1'b0, 1'b0);
    step(1'b1, 6'd33, 3'd5, 1'b1, 1'b0);
    check("full_pop_count", 32'(count), 32'd3);
    step(1'b1, 6'd34, 3'd6, 1'b0, 1'b0);
    check("refill_count", 32'(count), 32'd4);

    // Reset mid-stream
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 6'd44, 3'd7, 1'b0, 1'b1);
    check("midreset_count", 32'(count), 32'd0);

    // Drop counter saturation
    for (int i = 0; i < 304; i++) step(1'b1, 6'($urandom), 3'($urandom), 1'b0, 1'b0);
    check("drop_saturated", 32'(drop_cnt), 32'd255);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom), 3'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
